// File: rtl/sync_edge_filter.sv
// Glitch filter for a synchronized level: accepts a new level only after it holds for
// cfg_filt_len+1 samples. Optional edge counter enabled by SYNC_EDGE_FILTER_CNT_EN.
module sync_edge_filter #(
    parameter int unsigned FILT_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              sync_in,
    input  logic [FILT_W-1:0] cfg_filt_len,
    input  logic              clr_cnt,
    output logic              level_out,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic              busy,
    output logic [CNT_W-1:0]  edge_cnt
);

    typedef enum logic {StIdle, StQual} state_e;

    state_e            state;
    logic [FILT_W-1:0] qual_cnt;
    logic              differ;
    logic              len_met;
    logic              accept;

    assign differ  = (sync_in != level_out);
    // qual_cnt counts differing samples after the first, so the current sample makes it +1
    assign len_met = (({1'b0, qual_cnt} + (FILT_W+1)'(1)) >= {1'b0, cfg_filt_len});

    // Zero-length acceptance is held off for one cycle after a pulse so pulses never abut
    always_comb begin
        accept = 1'b0;
        if (state == StIdle) begin
            accept = differ && (cfg_filt_len == '0) && !(rise_pulse || fall_pulse);
        end else begin
            accept = differ && len_met;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= StIdle;
            qual_cnt   <= '0;
            level_out  <= 1'b1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rise_pulse <= accept && sync_in;
            fall_pulse <= accept && !sync_in;
            if (accept) begin
                level_out <= sync_in;
            end
            case (state)
                StIdle: begin
                    if (differ && (cfg_filt_len != '0)) begin
                        state    <= StQual;
                        qual_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                StQual: begin
                    if (!differ || len_met) begin
                        state    <= StIdle;
                        qual_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (qual_cnt != '1) begin
                        qual_cnt <= qual_cnt + FILT_W'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYNC_EDGE_FILTER_CNT_EN
    logic [CNT_W-1:0] edge_cnt_q;

    // Counts on the same edge that registers the pulse; clear has priority
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            edge_cnt_q <= '0;
        end else if (clr_cnt) begin
            edge_cnt_q <= '0;
        end else if (accept) begin
            edge_cnt_q <= edge_cnt_q + CNT_W'(1);
        end
    end

    assign edge_cnt = edge_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign edge_cnt       = '0;
`endif

endmodule
